// File: rtl/multimode_ring_counter.sv
// rtl/multimode_ring_counter.sv - Johnson/ring counter with direction, load and illegal-state correction
module multimode_ring_counter #(
  parameter int WIDTH = 4,
  localparam int PW = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  // Truncation is intended: 2*WIDTH - pop stays below 2**PW whenever pop >= 1.
  localparam logic [PW-1:0]    TWO_W = PW'(2*WIDTH);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_err;

  logic [WIDTH-1:0] w_plus1;
  logic [WIDTH-1:0] w_inv;
  logic [WIDTH-1:0] w_inv_plus1;
  logic [WIDTH-1:0] w_minus1;
  logic             w_j_legal;
  logic             w_r_legal;
  logic             w_legal;
  logic [WIDTH-1:0] w_next;
  logic             w_next_wrap;
  logic [PW-1:0]    w_pop;
  logic [PW-1:0]    w_jphase;
  logic [PW-1:0]    w_ridx;
  logic [PW-1:0]    w_phase;

  // Johnson-legal means the value or its inverse is a run of low-order ones.
  assign w_plus1     = r_count + ONE;
  assign w_inv       = ~r_count;
  assign w_inv_plus1 = w_inv + ONE;
  assign w_minus1    = r_count - ONE;
  assign w_j_legal   = ((r_count & w_plus1) == '0) || ((w_inv & w_inv_plus1) == '0);
  assign w_r_legal   = (r_count != '0) && ((r_count & w_minus1) == '0);
  assign w_legal     = mode ? w_r_legal : w_j_legal;

  always_comb begin
    w_next = r_count;
    case ({mode, dir})
      2'b00: w_next = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
      2'b01: w_next = {~r_count[0], r_count[WIDTH-1:1]};
      2'b10: w_next = {r_count[WIDTH-2:0], r_count[WIDTH-1]};
      2'b11: w_next = {r_count[0], r_count[WIDTH-1:1]};
      default: w_next = r_count;
    endcase
  end

  assign w_next_wrap = mode ? (w_next == ONE) : (w_next == '0);

  always_comb begin
    w_pop  = '0;
    w_ridx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + PW'(r_count[i]);
      if (r_count[i]) begin
        w_ridx = PW'(i);
      end
    end
  end

  assign w_jphase = (r_count[0] || (r_count == '0)) ? w_pop : (TWO_W - w_pop);
  assign w_phase  = !w_legal ? '0 : (mode ? w_ridx : w_jphase);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= ONE;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else if (load) begin
      r_count <= load_val;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else if (en) begin
      if (!w_legal) begin
        r_count <= ONE;
        r_wrap  <= 1'b0;
        r_err   <= 1'b1;
      end else begin
        r_count <= w_next;
        r_wrap  <= w_next_wrap;
        r_err   <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end
  end

  assign count = r_count;
  assign phase = w_phase;
  assign wrap  = r_wrap;
  assign err   = r_err;

endmodule

// File: tb/tb_multimode_ring_counter.sv
// tb/tb_multimode_ring_counter.sv - randomized and directed checks against a sequence-table model
module tb_multimode_ring_counter;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic         dir = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic [2:0]   phase;
  logic         wrap;
  logic         err;

  int total = 0;
  int bad   = 0;

  int m_cnt   = 1;
  bit m_wrap  = 1'b0;
  bit m_err   = 1'b0;
  bit m_valid = 1'b0;

  multimode_ring_counter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val),
    .count(count), .phase(phase), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  // Johnson sequence position p -> state: p ones from the bottom, then ones draining from the bottom.
  function automatic int jstate(int p);
    if (p <= W) return (1 << p) - 1;
    return MASK ^ ((1 << (p - W)) - 1);
  endfunction

  function automatic int lookup(bit md, int c);
    if (md) begin
      for (int p = 0; p < W; p++) if (c == (1 << p)) return p;
    end else begin
      for (int p = 0; p < 2*W; p++) if (c == jstate(p)) return p;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int idx, n, nidx;
    if (reset) begin
      m_cnt = 1; m_wrap = 0; m_err = 0; m_valid = 1;
    end else if (load) begin
      m_cnt = int'(load_val); m_wrap = 0; m_err = 0;
    end else if (en) begin
      idx = lookup(mode, m_cnt);
      if (idx < 0) begin
        m_cnt = 1; m_wrap = 0; m_err = 1;
      end else begin
        n    = mode ? W : 2*W;
        nidx = dir ? (idx + n - 1) % n : (idx + 1) % n;
        m_cnt  = mode ? (1 << nidx) : jstate(nidx);
        m_wrap = (nidx == 0);
        m_err  = 0;
      end
    end else begin
      m_wrap = 0; m_err = 0;
    end
  end

  always @(negedge clk) begin
    int mi;
    if (m_valid) begin
      mi = lookup(mode, m_cnt);
      chk("model_count", int'(count), m_cnt);
      chk("model_phase", int'(phase), (mi < 0) ? 0 : mi);
      chk("model_wrap",  int'(wrap),  int'(m_wrap));
      chk("model_err",   int'(err),   int'(m_err));
    end
  end

  task automatic drive(input logic r, input logic l, input logic [W-1:0] lv,
                       input logic e, input logic m, input logic d);
    reset = r; load = l; load_val = lv; en = e; mode = m; dir = d;
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input int c, input int p, input int wr, input int er);
    chk({nm, "_count"}, int'(count), c);
    chk({nm, "_phase"}, int'(phase), p);
    chk({nm, "_wrap"},  int'(wrap),  wr);
    chk({nm, "_err"},   int'(err),   er);
  endtask

  initial begin
    int jc[8];
    bit rm, rd;
    jc = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};

    drive(1, 0, 4'b0000, 0, 0, 0);
    lit("reset", 1, 1, 0, 0);

    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 4'b0000, 1, 0, 0);
      lit("jup", jc[i], (i + 2) % 8, (jc[i] == 0) ? 1 : 0, 0);
    end

    drive(1, 0, 4'b0000, 0, 0, 0);
    drive(0, 0, 4'b0000, 1, 0, 1);
    lit("jdn0", 4'b0000, 0, 1, 0);
    drive(0, 0, 4'b0000, 1, 0, 1);
    lit("jdn1", 4'b1000, 7, 0, 0);
    drive(0, 0, 4'b0000, 1, 0, 1);
    lit("jdn2", 4'b1100, 6, 0, 0);

    drive(1, 0, 4'b0000, 0, 1, 1);
    lit("rreset", 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 4'b0000, 1, 1, 1);
      lit("rdn", 8 >> i, 3 - i, (i == 3) ? 1 : 0, 0);
    end

    drive(0, 1, 4'b0101, 0, 0, 0);
    lit("ldill", 4'b0101, 0, 0, 0);
    drive(0, 0, 4'b0000, 1, 0, 0);
    lit("corr", 4'b0001, 1, 0, 1);
    drive(0, 0, 4'b0000, 1, 0, 0);
    lit("jstep", 4'b0011, 2, 0, 0);
    drive(0, 0, 4'b0000, 1, 1, 0);
    lit("mcorr", 4'b0001, 0, 0, 1);

    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 4'b1010, 0, 1, 0);
      lit("hold", 4'b0001, 0, 0, 0);
    end
    drive(1, 1, 4'b1010, 1, 1, 1);
    lit("prio", 4'b0001, 0, 0, 0);

    rm = 0; rd = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) rm = ~rm;
      if ($urandom_range(0, 7) == 0)  rd = ~rd;
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 11) == 0,
            W'($urandom_range(0, MASK)), $urandom_range(0, 3) != 0, rm, rd);
    end

    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multimode_ring_counter.md
MULTIMODE_RING_COUNTER -- requirements
Module: multimode_ring_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, legal range 2..32, which sets the number of counter stages.
REQ-002 The block SHALL have local parameter PW = $clog2(2*WIDTH), which sets the phase output width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  step enable; one shift per cycle while high.
REQ-006 mode  input  1  0 = Johnson (twisted ring, 2*WIDTH states), 1 = ring (one-hot, WIDTH states).
REQ-007 dir  input  1  0 = shift toward MSB, 1 = shift toward LSB.
REQ-008 load  input  1  synchronous parallel load strobe.
REQ-009 load_val  input  WIDTH  value taken by count on load.
REQ-010 count  output  WIDTH  registered counter state.
REQ-011 phase  output  PW  position of count within the current mode's sequence.
REQ-012 wrap  output  1  registered one-cycle pulse when an enabled step lands on phase 0.
REQ-013 err  output  1  registered one-cycle pulse when an illegal state is corrected.

Function
REQ-014 The update priority per rising edge SHALL be reset > load > en > hold.
REQ-015 Johnson, dir=0: next count = {count[W-2:0], ~count[W-1]}.
REQ-016 Johnson, dir=1: next count = {~count[0], count[W-1:1]}.
REQ-017 Ring, dir=0: next count = {count[W-2:0], count[W-1]}.
REQ-018 Ring, dir=1: next count = {count[0], count[W-1:1]}.
REQ-019 A Johnson-legal state SHALL be 0...01...1 or 1...10...0, including all-zeros and all-ones; a ring-legal state SHALL have exactly one bit set.
REQ-020 When en=1, load=0 and count is illegal for the current mode, count SHALL become 1 (bit0 only) instead of stepping.
REQ-021 In the REQ-020 case, err SHALL be 1 for that cycle and wrap SHALL be 0.
REQ-022 Load SHALL ignore en and SHALL accept any value, legal or not.
REQ-023 An illegal loaded value SHALL be corrected on the next enabled step, not at load time.
REQ-024 On load, wrap and err SHALL be 0.
REQ-025 A mode or dir change SHALL take effect on the next enabled step, with no reset of count.
REQ-026 After a mode change, a state illegal for the new mode SHALL be handled per REQ-020.
REQ-027 Johnson phase, combinational from count: if count[0]=1 or count=0, phase = popcount(count); else phase = 2*WIDTH - popcount(count).
REQ-028 Ring phase, combinational from count: phase = index of the set bit.
REQ-029 phase SHALL be 0 whenever count is illegal for the current mode.
REQ-030 wrap SHALL be 1 in exactly the cycle following an enabled, non-correcting step whose result is phase 0 (Johnson all-zeros; ring bit0 set).
REQ-031 wrap SHALL be 0 in every other cycle.
REQ-032 While en=0 and load=0, count SHALL hold and wrap and err SHALL be 0.
REQ-033 Both dir values SHALL traverse the same state set in opposite order, and wrap SHALL apply in both directions.

Reset
REQ-034 With reset=1 at a rising edge, count SHALL become 1 (bit0 only), and wrap and err SHALL become 0, regardless of load, en, mode and dir.
REQ-035 The reset value SHALL be legal in both modes, giving phase 1 in Johnson and phase 0 in ring.
REQ-036 Reset asserted mid-sequence SHALL take effect at the next edge with no partial step.

Verification (WIDTH=4)
REQ-037 Johnson up: reset, then mode=0 dir=0 en=1 for 8 cycles -> count 0011,0111,1111,1110,1100,1000,0000,0001; phase 2..7,0,1; wrap=1 only while count=0000.
REQ-038 Johnson down: from reset, mode=0 dir=1 en=1 -> count 0000 (phase 0, wrap=1), then 1000 (phase 7), then 1100 (phase 6).
REQ-039 Ring down: from reset, mode=1 dir=1 en=1 -> count 1000,0100,0010,0001; phase 3,2,1,0; wrap=1 only at 0001.
REQ-040 Illegal correction: load=1 load_val=0101 mode=0, then en=1 -> count 0101 with phase 0, then count 0001 with err=1 and wrap=0; then mode=1 at count 0011 with en=1 -> count 0001 and err=1.
REQ-041 Hold and priority: en=0 for 5 cycles -> count and phase unchanged, wrap=err=0; then reset=load=en=1 together -> count 0001, wrap=0, err=0.
